// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: 1 ms prescaler, step counter and a mode FSM
// driving OFF / BLINK / CHASE / BOUNCE patterns on four LEDs.
module led_pattern_sequencer #(
    parameter int unsigned TICK_DIV   = 50_000,
    parameter int unsigned STEP_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mode_next,
    input  logic [1:0] period_sel,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(STEP_TICKS * 8);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_BLINK  = 2'd1,
        M_CHASE  = 2'd2,
        M_BOUNCE = 2'd3
    } mode_e;

    mode_e         mode_q, mode_d;
    logic [3:0]    pat_q, pat_d;
    logic          dir_dn_q, dir_dn_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] step_q, step_d;
    logic [1:0]    psel_q, psel_d;
    logic [3:0]    led_q, led_d;
    logic          tick_q, tick_d;

    logic [SW-1:0] lim_m1;
    logic          wrap;
    logic          step_fire;

    // Last step-counter value of the current period, from the latched multiplier.
    always_comb begin
        lim_m1    = SW'((STEP_TICKS << psel_q) - 1);
        wrap      = enable && (presc_q == PMAX);
        step_fire = wrap && (step_q == lim_m1);
    end

    // Next-state: mode change beats a step; disable freezes everything.
    always_comb begin
        mode_d   = mode_q;
        pat_d    = pat_q;
        dir_dn_d = dir_dn_q;
        presc_d  = presc_q;
        step_d   = step_q;
        psel_d   = psel_q;
        if (mode_next) begin
            mode_d   = mode_e'(mode_q + 2'd1);
            presc_d  = '0;
            step_d   = '0;
            psel_d   = period_sel;
            dir_dn_d = 1'b0;
            unique case (mode_d)
                M_OFF:    pat_d = 4'b0000;
                M_BLINK:  pat_d = 4'b1111;
                M_CHASE:  pat_d = 4'b0001;
                M_BOUNCE: pat_d = 4'b0001;
            endcase
        end else if (enable) begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
            if (wrap) begin
                step_d = step_fire ? '0 : step_q + 1'b1;
            end
            if (step_fire) begin
                psel_d = period_sel;
                unique case (mode_q)
                    M_OFF:   pat_d = pat_q;
                    M_BLINK: pat_d = ~pat_q;
                    M_CHASE: pat_d = {pat_q[2:0], pat_q[3]};
                    M_BOUNCE: begin
                        if (!dir_dn_q) begin
                            pat_d = pat_q << 1;
                            if (pat_q == 4'b0100) dir_dn_d = 1'b1;
                        end else begin
                            pat_d = pat_q >> 1;
                            if (pat_q == 4'b0010) dir_dn_d = 1'b0;
                        end
                    end
                endcase
            end
        end
        tick_d = enable && (presc_d == PMAX);
        led_d  = (enable && (mode_q != M_OFF)) ? pat_q : 4'b0000;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= M_OFF;
            pat_q    <= 4'b0000;
            dir_dn_q <= 1'b0;
            presc_q  <= '0;
            step_q   <= '0;
            psel_q   <= 2'd0;
            led_q    <= 4'b0000;
            tick_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pat_q    <= pat_d;
            dir_dn_q <= dir_dn_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            psel_q   <= psel_d;
            led_q    <= led_d;
            tick_q   <= tick_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with TICK_DIV=4, STEP_TICKS=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       mode_next;
    logic [1:0] period_sel;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;

    int errs   = 0;
    int checks = 0;

    logic [3:0] mled [4] = '{4'hF, 4'h1, 4'h1, 4'h0};
    logic [3:0] bseq [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

    led_pattern_sequencer #(
        .TICK_DIV  (4),
        .STEP_TICKS(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode_next (mode_next),
        .period_sel(period_sel),
        .led       (led),
        .mode      (mode),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        mode_next = 1'b1;
        @(negedge clk);
        mode_next = 1'b0;
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] p;
        rst        = 1'b0;
        enable     = 1'b1;
        mode_next  = 1'b0;
        period_sel = 2'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mode_next = ~mode_next;
        end
        @(negedge clk);
        chk("rst_led", 8'(led), 8'h0);
        chk("rst_mode", 8'(mode), 8'h0);
        chk("rst_tick", 8'(tick), 8'h0);
        mode_next = 1'b0;
        rst       = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("tick_cadence", 8'(tick), 8'(i % 4 == 3));
        end

        for (int i = 0; i < 4; i++) begin
            pulse();
            chk("cyc_mode", 8'(mode), 8'((i + 1) % 4));
            cyc(1);
            chk("cyc_led", 8'(led), 8'(mled[i]));
            if (i < 3) cyc(18);
        end

        pulse();
        pulse();
        chk("chase_mode", 8'(mode), 8'h2);
        cyc(1);
        chk("chase_init", 8'(led), 8'h1);
        for (int s = 1; s <= 9; s++) begin
            p = 4'(1 << ((s - 1) % 4));
            e = 4'(1 << (s % 4));
            cyc(7);
            chk("chase_hold", 8'(led), 8'(p));
            cyc(1);
            chk("chase_step", 8'(led), 8'(e));
        end

        pulse();
        chk("bounce_mode", 8'(mode), 8'h3);
        cyc(1);
        chk("bounce_init", 8'(led), 8'(bseq[0]));
        for (int s = 1; s < 8; s++) begin
            cyc(7);
            chk("bounce_hold", 8'(led), 8'(bseq[s-1]));
            cyc(1);
            chk("bounce_step", 8'(led), 8'(bseq[s]));
        end

        pulse();
        pulse();
        chk("blink_mode", 8'(mode), 8'h1);
        cyc(3);
        period_sel = 2'd2;
        cyc(5);
        chk("psel_k8", 8'(led), 8'hF);
        cyc(1);
        chk("psel_k9", 8'(led), 8'h0);
        cyc(31);
        chk("psel_k40", 8'(led), 8'h0);
        cyc(1);
        chk("psel_k41", 8'(led), 8'hF);
        cyc(9);
        period_sel = 2'd0;
        cyc(3);
        period_sel = 2'd2;
        cyc(19);
        chk("psel_k72", 8'(led), 8'hF);
        cyc(1);
        chk("psel_k73", 8'(led), 8'h0);

        period_sel = 2'd0;
        pulse();
        chk("coll_pre_mode", 8'(mode), 8'h2);
        cyc(7);
        pulse();
        chk("coll_mode", 8'(mode), 8'h3);
        cyc(1);
        chk("coll_led", 8'(led), 8'h1);
        cyc(2);
        chk("frz_tick_pre", 8'(tick), 8'h1);
        enable = 1'b0;
        cyc(1);
        chk("frz_led", 8'(led), 8'h0);
        chk("frz_tick", 8'(tick), 8'h0);
        cyc(12);
        chk("frz_led_end", 8'(led), 8'h0);
        chk("frz_tick_end", 8'(tick), 8'h0);
        enable = 1'b1;
        cyc(1);
        chk("resume_led", 8'(led), 8'h1);
        cyc(4);
        chk("resume_hold", 8'(led), 8'h1);
        cyc(1);
        chk("resume_step", 8'(led), 8'h2);
        cyc(8);
        chk("bounce_0100", 8'(led), 8'h4);

        #2;
        rst = 1'b0;
        #1;
        chk("async_led", 8'(led), 8'h0);
        chk("async_mode", 8'(mode), 8'h0);
        chk("async_tick", 8'(tick), 8'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(3);
        chk("post_rst_led", 8'(led), 8'h0);
        chk("post_rst_mode", 8'(mode), 8'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Sequences a 4-LED bank through selectable blink patterns on the 50 MHz board clock. A prescaler produces a 1 ms tick and a step counter produces pattern steps. A mode FSM advances on a single-cycle request pulse from the already-debounced push-button logic. The block is the board's LED controller: it owns timing and pattern selection, and the top level only wires LED pins and the button pulse.

Parameters:
TICK_DIV, 50_000, clk cycles per tick (1 ms at 50 MHz); must be >= 2
STEP_TICKS, 250, ticks per pattern step at period_sel=0; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
enable  input  1  run when 1; freeze counters and blank LEDs when 0
mode_next  input  1  single-cycle pulse: advance to next mode
period_sel  input  2  step period multiplier = 2^period_sel (x1, x2, x4, x8)
led  output  4  LED drive, registered, 1 = on
mode  output  2  current mode, registered
tick  output  1  one-cycle pulse per prescaler wrap

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous deassert at top level): led=0000, mode=0, tick=0, prescaler=0, step counter=0, bounce direction=up, pattern register=0000.
- Prescaler counts 0..TICK_DIV-1 while enable=1. tick=1 during the cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
- Step counter counts ticks 0..limit-1, where limit = STEP_TICKS << period_sel_q and period_sel_q is a registered copy of period_sel.
- A step pulse fires on the tick that reaches limit-1; the counter then wraps to 0. Counter width covers STEP_TICKS*8-1.
- period_sel_q reloads only on a step pulse, on mode_next, or at reset. Mid-step changes never shorten or stretch the current step.
- Modes and their patterns:
  - 0 OFF: led=0000 always.
  - 1 BLINK: initial pattern 1111; each step inverts all bits.
  - 2 CHASE: initial pattern 0001; each step rotates left (0001→0010→0100→1000→0001).
  - 3 BOUNCE: initial pattern 0001, direction up; each step shifts one position in the current direction. Direction flips when 1000 or 0001 is reached, so the sequence runs 0001,0010,0100,1000,0100,0010,0001,0010...
- mode_next=1 at edge n: at edge n+1, mode=(mode+1) mod 4 (3 wraps to 0).
  - The pattern loads the new mode's initial value and direction resets to up.
  - The prescaler and step counter clear to 0, so the first step of the new mode occurs a full period later.
- mode_next and a step pulse in the same cycle: mode_next wins and the step is discarded.
- mode_next while enable=0: accepted. Mode and pattern update; counters stay cleared.
- enable=0:
  - The prescaler and step counter hold their values.
  - tick=0 and no step fires.
  - led is forced to 0000 from the next edge.
  - Pattern and direction are held.
- enable returning to 1: led shows the held pattern from the next edge and counting resumes from the held values.
- led is registered: led at edge n+1 = (enable && mode!=0) ? pattern : 0000, using values after the edge-n updates. This gives one cycle of latency from a pattern change to the pin.
- No combinational path from any input to any output.

Test Plan:
- Use TICK_DIV=4, STEP_TICKS=2 for all scenarios (one step = 8 cycles at period_sel=0).
- Reset: hold rst=0 for 3 cycles with mode_next pulsing → led=0000, mode=0, tick=0. After release with enable=1, tick pulses every 4th cycle.
- Mode cycling: four mode_next pulses spaced 20 cycles apart → mode goes 1,2,3,0, each one cycle after its pulse. led loads 1111, 0001, 0001, 0000 at the corresponding times.
- CHASE and BOUNCE sequences: in mode 2, run 9 steps → led 0001,0010,0100,1000,0001,... with a change every 8 cycles. In mode 3, run 7 steps → 0001,0010,0100,1000,0100,0010,0001,0010.
- period_sel: set period_sel=2 mid-step in BLINK → the current step completes at 8 cycles and following steps take 32 cycles. A pulse of period_sel back to 0 for 3 cycles mid-step has no effect.
- Collision and freeze: assert mode_next in the exact cycle a step fires in CHASE → mode=3, led=0001, no rotation. Drop enable for 13 cycles → led=0000 and the counter holds. Re-enable → the next step lands exactly the remaining cycles later.
- Async reset mid-pattern: pull rst low between clock edges in BOUNCE at 0100 → led=0000 and mode=0 immediately, without waiting for a clock edge.
